stream_fifo: RTL and testbench

Parametrised synchronous stream buffer with a valid/ready handshake on both sides. It generalises the fixed shift-register delay line into a depth-configurable, backpressure-aware FIFO. It carries occupancy and almost-full/almost-empty indication for upstream throttling. It sits between producer and consumer pipeline stages in the same clock domain.

---
 rtl/stream_fifo.sv | 128 ++++++++++++
 tb/tb_stream_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous valid/ready FIFO with first-word-fall-through read,
// occupancy output and registered almost-full / almost-empty flags.
// Optional high-water-mark tracking is enabled by defining STREAM_FIFO_WATERMARK_EN,
// which adds the wm_clear input and the max_level output.
module stream_fifo #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned AFULL_THRESH  = DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1,
  localparam int unsigned AW           = $clog2(DEPTH),
  localparam int unsigned LW           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [LW-1:0]    level,
  output logic             almost_full,
`ifdef STREAM_FIFO_WATERMARK_EN
  output logic             almost_empty,
  input  logic             wm_clear,
  output logic [LW-1:0]    max_level
`else
  output logic             almost_empty
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             push, pop;

  // Handshake qualifiers; ready/valid depend on registered occupancy only.
  always_comb begin
    s_ready = (level_q != LW'(DEPTH));
    m_valid = (level_q != '0);
    push    = s_valid && s_ready;
    pop     = m_valid && m_ready;
  end

  // Next-state pointers, occupancy and flags computed from next-state level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    afull_d  = (level_d >= LW'(AFULL_THRESH));
    aempty_d = (level_d <= LW'(AEMPTY_THRESH));
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage write; contents are never cleared, a reset edge just blocks the write.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // Output drive: head of queue falls through, flags straight from registers.
  always_comb begin
    m_data       = mem_q[rd_ptr_q];
    level        = level_q;
    almost_full  = afull_q;
    almost_empty = aempty_q;
  end

`ifdef STREAM_FIFO_WATERMARK_EN
  logic [LW-1:0] max_q, max_d;

  // High-water mark; a clear coinciding with a push restarts from the new level.
  always_comb begin
    max_d = max_q;
    if (wm_clear) begin
      max_d = push ? level_d : '0;
    end else if (level_d > max_q) begin
      max_d = level_d;
    end
  end

  // Watermark register.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  // Watermark output.
  always_comb begin
    max_level = max_q;
  end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo using a queue scoreboard and occupancy model.
// Define STREAM_FIFO_WATERMARK_EN to also exercise the high-water-mark port.
module tb_stream_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [LW-1:0]    level;
  logic             almost_full;
  logic             almost_empty;
`ifdef STREAM_FIFO_WATERMARK_EN
  logic             wm_clear;
  logic [LW-1:0]    max_level;
  int               exp_max;
`endif

  int               checks;
  int               failures;
  logic [WIDTH-1:0] exp_q [$];

  stream_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (DEPTH - 1),
    .AEMPTY_THRESH(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .level       (level),
    .almost_full (almost_full),
`ifdef STREAM_FIFO_WATERMARK_EN
    .almost_empty(almost_empty),
    .wm_clear    (wm_clear),
    .max_level   (max_level)
`else
    .almost_empty(almost_empty)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: account handshakes from the model, advance, then compare state.
  task automatic step();
    bit               push;
    bit               pop;
    int               lvl;
    logic [WIDTH-1:0] exp;
    if (rst) begin
      exp_q.delete();
`ifdef STREAM_FIFO_WATERMARK_EN
      exp_max = 0;
`endif
    end else begin
      push = s_valid && (exp_q.size() != DEPTH);
      pop  = m_ready && (exp_q.size() != 0);
      if (pop) begin
        exp = exp_q.pop_front();
        check_eq("m_data", 32'(m_data), 32'(exp));
      end
      if (push) exp_q.push_back(s_data);
`ifdef STREAM_FIFO_WATERMARK_EN
      if (wm_clear) exp_max = push ? exp_q.size() : 0;
      else if (exp_q.size() > exp_max) exp_max = exp_q.size();
`endif
    end
    @(posedge clk);
    #1;
    lvl = exp_q.size();
    check_eq("level", 32'(level), 32'(lvl));
    check_eq("m_valid", 32'(m_valid), 32'(lvl != 0));
    check_eq("s_ready", 32'(s_ready), 32'(lvl != DEPTH));
    check_eq("almost_full", 32'(almost_full), 32'(lvl >= DEPTH - 1));
    check_eq("almost_empty", 32'(almost_empty), 32'(lvl <= 1));
`ifdef STREAM_FIFO_WATERMARK_EN
    check_eq("max_level", 32'(max_level), 32'(exp_max));
`endif
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    m_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b0;
`ifdef STREAM_FIFO_WATERMARK_EN
    wm_clear = 1'b0;
    exp_max  = 0;
`endif
    step();
    step();
    rst = 1'b0;

    // Three back-to-back pushes with consumer stalled, then drain in order.
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    check_eq("three_level", 32'(level), 32'd3);
    check_eq("three_afull", 32'(almost_full), 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    m_ready = 1'b0;
    check_eq("drained_aempty", 32'(almost_empty), 32'd1);

    // Fill, hold a blocked push, free one slot, see it accepted.
    for (int i = 0; i < DEPTH; i++) push_word(WIDTH'(8'hC0 + i));
    s_valid = 1'b1;
    s_data  = 8'h55;
    step();
    step();
    check_eq("full_blocked_level", 32'(level), 32'(DEPTH));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check_eq("ready_after_pop", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    drain();

    // Single-cycle latency into an empty FIFO.
    check_eq("a5_mvalid_before", 32'(m_valid), 32'd0);
    push_word(8'hA5);
    check_eq("a5_mvalid_after", 32'(m_valid), 32'd1);
    check_eq("a5_data", 32'(m_data), 32'hA5);
    drain();

    // Steady state at level 2 with simultaneous push/pop across pointer wraps.
    push_word(8'hE0);
    push_word(8'hE1);
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = WIDTH'(i);
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check_eq("steady_level", 32'(level), 32'd2);
    drain();

    // Reset mid-operation discards stored words.
    push_word(8'h77);
    push_word(8'h88);
    push_word(8'h99);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_sready", 32'(s_ready), 32'd1);
    push_word(8'h42);
    drain();

`ifdef STREAM_FIFO_WATERMARK_EN
    // High-water mark: fill to 3, drain, clear, one push.
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    drain();
    check_eq("wm_peak", 32'(max_level), 32'd3);
    wm_clear = 1'b1;
    step();
    wm_clear = 1'b0;
    check_eq("wm_cleared", 32'(max_level), 32'd0);
    push_word(8'h04);
    check_eq("wm_one", 32'(max_level), 32'd1);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
